pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction fetch and PC-sequencing stage for the single-cycle MIPS core. It sits directly upstream of the main opcode decoder.

- Holds the program counter and requests the instruction word from instruction memory over a req/ack handshake.
- Presents the latched instruction to decode and execute for one execute window.
- Computes the next PC from the decoder's `Jump`, `Branch` and `bne` outputs and the ALU `zero` flag.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_addr`, out, 32: fetch address; always equals `pc`.
- `imem_req`, out, 1: fetch request.
- `imem_ack`, in, 1: instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata`, in, 32: instruction word.
- `inst`, out, 32: latched instruction; `inst[31:26]` drives the decoder op input.
- `inst_valid`, out, 1: `inst` is being executed this cycle.
- `pc`, out, 32: address of the current instruction.
- `pc_plus4`, out, 32: `pc + 4`; this is the link value for jal.
- `Jump`, in, 1: from the decoder.
- `Branch`, in, 1: beq, from the decoder.
- `bne`, in, 1: from the decoder.
- `zero`, in, 1: ALU zero flag for the current instruction.
- `stall`, in, 1: hold the current instruction in EXEC.

## Operation
FSM states: IDLE, FETCH, EXEC.

- **IDLE**
  - Entered on reset.
  - Always moves to FETCH on the next cycle.
- **FETCH**
  - `imem_req`=1.
  - On `imem_ack`=1: latch `imem_rdata` into `inst` and go to EXEC.
  - Otherwise remain in FETCH with `req` held high.
- **EXEC**
  - `inst_valid`=1, `imem_req`=0.
  - If `stall`=1: remain in EXEC; `pc` and `inst` are unchanged.
  - Else: `pc` <= `next_pc` and go to FETCH.

Next-PC selection (combinational; priority as listed):
1. `Jump`: {`pc_plus4[31:28]`, `inst[25:0]`, 2'b00}.
2. `taken` = (`Branch` & `zero`) | (`bne` & ~`zero`). If `taken`: `pc_plus4` + {sign-extend(`inst[15:0]`), 2'b00}, computed mod 2^32.
3. Otherwise: `pc_plus4`.

Rules:
- `Branch` and `bne` both high is a decoder error. `taken` still evaluates as the OR above; there is no special handling.
- `imem_ack` is ignored in IDLE and EXEC.
- `inst`, `pc` and `pc_plus4` are stable throughout EXEC.

## Timing
Reset values (synchronous, `rst`=1 at a rising edge):
- state=IDLE, `pc`=`RESET_PC`, `inst`=0.
- `imem_req`=0, `inst_valid`=0.
- `pc_plus4`=`RESET_PC`+4.

Cycle behaviour:
- Minimum throughput is 2 cycles per instruction: FETCH with ack in the same cycle, then EXEC.
- First `imem_req` is asserted in the second cycle after reset deasserts.
- `imem_req` rises on entry to FETCH and stays high until the ack edge.
- `imem_addr` is stable while `req` is high.
- The new `pc` is visible in the cycle after the last EXEC cycle, which is the first FETCH cycle.

Boundary conditions:
- **Reset mid-FETCH:** the request is abandoned and the FSM returns to IDLE. A late ack arriving in IDLE is ignored. The next fetch is from `RESET_PC`.
- **Reset during EXEC:** the PC update is suppressed and reset wins.
- **`stall` during FETCH:** no effect.
- **PC wrap:** from `pc`=32'hFFFF_FFFC, sequential next is 0.
- **Branch wrap:** branch targets wrap mod 2^32.
- **Alignment:** `pc[1:0]` is always 00, provided `RESET_PC` is word-aligned.

## Structure
Shared package `mips_pkg`:
- FSM state enum (IDLE/FETCH/EXEC).
- Default `RESET_PC`.
- Opcode constants shared with the decoder.

Sub-module `next_pc_calc`:
- Purely combinational.
- Inputs: `pc_plus4`, `inst[25:0]`, `Jump`, `Branch`, `bne`, `zero`.
- Output: `next_pc`.

`pc_fetch` holds only the FSM and registers.

## Test plan
- **Reset and sequential fetch.** Reset with `RESET_PC`=0, memory acks immediately, NOP stream. Required: `imem_addr` sequence 0, 4, 8, C; `inst_valid` pulses every 2nd cycle.
- **beq taken and not taken.** At `pc`=0x10, `inst[15:0]`=16'hFFFE, `Branch`=1.
  - `zero`=1 → next `pc`=0x0C.
  - `zero`=0 → next `pc`=0x14.
- **bne and jump.**
  - bne, `zero`=0, offset 3, at `pc`=0x20 → next `pc`=0x30.
  - `Jump`, `inst[25:0]`=26'h40, at `pc`=0x3000_0000 → next `pc`=0x3000_0100.
  - `pc_plus4`=0x3000_0004 during EXEC.
- **Memory wait and stall.**
  - Ack delayed 3 cycles → `imem_req` high for 4 cycles with constant `addr`.
  - `stall` high for 2 EXEC cycles → `inst_valid` held for 3 cycles, `pc` unchanged.
- **Reset mid-fetch and wrap.**
  - Assert `rst` in FETCH, then deliver ack in IDLE → ignored; next fetch at `RESET_PC`.
  - `RESET_PC`=32'hFFFF_FFFC, sequential → second fetch address 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch and decode stages: FSM encodings,
// the default reset PC, opcode constants and the branch offset helper.
package mips_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Word offset of a branch immediate, as a signed byte displacement.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, then taken branch, then fall-through.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_inst_idx,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_bne,
  input  logic        i_zero,
  output logic [31:0] o_next_pc
);

  logic               w_taken;
  logic signed [31:0] w_offset;

  // beq and bne together simply OR; the decoder should never assert both.
  assign w_taken  = (i_branch & i_zero) | (i_bne & ~i_zero);
  assign w_offset = branch_offset(i_inst_idx[15:0]);

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = {i_pc_plus4[31:28], i_inst_idx, 2'b00};
    end else if (w_taken) begin
      o_next_pc = i_pc_plus4 + $unsigned(w_offset);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch and PC-sequencing stage: IDLE -> FETCH (req/ack) -> EXEC -> FETCH.
// Holds the PC and the latched instruction; next-PC math lives in next_pc_calc.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        stall
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_calc u_next_pc_calc (
    .i_pc_plus4 (w_pc_plus4),
    .i_inst_idx (r_inst[25:0]),
    .i_jump     (Jump),
    .i_branch   (Branch),
    .i_bne      (bne),
    .i_zero     (zero),
    .o_next_pc  (w_next_pc)
  );

  // pc and inst only move on the FETCH->EXEC and EXEC->FETCH edges, so they
  // are stable for the whole EXEC window including stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign imem_req   = (r_state == ST_FETCH);
  assign inst       = r_inst;
  assign inst_valid = (r_state == ST_EXEC);
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: three instances with different RESET_PC,
// one active at a time, driven by a memory responder and a per-instruction driver.
module tb_pc_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sel;
  logic        force_ack, resp_ack, ack;
  logic [31:0] resp_rdata, rdata;
  logic        zero, stall, jump_s, branch_s, bne_s;
  logic        fetch_stall, mon_en;

  logic        rst_v   [3];
  logic [31:0] addr_v  [3];
  logic [31:0] inst_v  [3];
  logic [31:0] pc_v    [3];
  logic [31:0] pc4_v   [3];
  logic        req_v   [3];
  logic        valid_v [3];

  logic [31:0] m_addr, m_inst, m_pc, m_pc4;
  logic        m_req, m_valid;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [31:0] RP = (g == 0) ? 32'h0000_0000 :
                                 (g == 1) ? 32'h3000_0000 : 32'hFFFF_FFFC;
    assign rst_v[g] = rst | (sel != 2'(g));
    pc_fetch #(.RESET_PC(RP)) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .imem_addr  (addr_v[g]),
      .imem_req   (req_v[g]),
      .imem_ack   (ack),
      .imem_rdata (rdata),
      .inst       (inst_v[g]),
      .inst_valid (valid_v[g]),
      .pc         (pc_v[g]),
      .pc_plus4   (pc4_v[g]),
      .Jump       (jump_s),
      .Branch     (branch_s),
      .bne        (bne_s),
      .zero       (zero),
      .stall      (stall)
    );
  end

  always_comb begin
    m_addr  = addr_v[sel];
    m_inst  = inst_v[sel];
    m_pc    = pc_v[sel];
    m_pc4   = pc4_v[sel];
    m_req   = req_v[sel];
    m_valid = valid_v[sel];
  end

  assign ack      = force_ack | resp_ack;
  assign rdata    = force_ack ? 32'hDEAD_BEEF : resp_rdata;
  assign jump_s   = (m_inst[31:26] == 6'h02) || (m_inst[31:26] == 6'h03);
  assign branch_s = (m_inst[31:26] == 6'h04);
  assign bne_s    = (m_inst[31:26] == 6'h05);

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1000_FFFE;  // beq offset -2
      32'h0000_0014: return 32'h0800_0008;  // j 0x20
      32'h0000_0020: return 32'h1400_0003;  // bne offset 3
      32'h3000_0000: return 32'h0800_0040;  // j idx 0x40
      default:       return 32'h0000_0000;
    endcase
  endfunction

  function automatic int mem_delay(input logic [31:0] a);
    case (a)
      32'h0000_0034: return 3;
      32'h0000_0038: return 20;
      default:       return 0;
    endcase
  endfunction

  typedef struct {logic [31:0] addr; int len;} fch_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic [31:0] pc4; int len;} exe_t;
  typedef struct {logic z; int st;} stim_t;

  fch_t  fch_q[$];
  exe_t  exe_q[$];
  stim_t stim_q[$];

  int n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic exp_fetch(input logic [31:0] a, input int len);
    fch_t f;
    f.addr = a; f.len = len;
    fch_q.push_back(f);
  endtask

  task automatic exp_exec(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4,
                          input int len, input logic z, input int st);
    exe_t  e;
    stim_t s;
    e.pc = p; e.inst = i; e.pc4 = p4; e.len = len;
    s.z = z; s.st = st;
    exe_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Memory responder: acks mem_delay(addr) cycles into a request.
  int wcnt;
  initial begin
    resp_ack = 1'b0; resp_rdata = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (wcnt >= mem_delay(m_addr)) begin
          resp_ack   = 1'b1;
          resp_rdata = mem_rd(m_addr);
        end else begin
          resp_ack = 1'b0;
        end
        wcnt++;
      end else begin
        wcnt     = 0;
        resp_ack = 1'b0;
      end
    end
  end

  // Per-instruction driver for zero and stall.
  logic  dv_prev;
  int    stall_left;
  stim_t cur_s;
  initial begin
    zero = 1'b0; stall = 1'b0; dv_prev = 1'b0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (m_valid && !dv_prev) begin
        if (stim_q.size() > 0) begin
          cur_s      = stim_q.pop_front();
          zero       = cur_s.z;
          stall_left = cur_s.st;
        end else begin
          zero       = 1'b0;
          stall_left = 0;
        end
      end else if (m_valid && stall_left > 0) begin
        stall_left--;
      end
      stall   = m_valid ? (stall_left > 0) : fetch_stall;
      dv_prev = m_valid;
    end
  end

  // Monitor: one fetch record per request burst, one exec record per EXEC window.
  logic        in_f, f_bad, in_e, e_bad;
  int          f_len, e_len;
  logic [31:0] f_addr, e_pc, e_inst, e_pc4;
  fch_t        fr;
  exe_t        er;
  initial begin
    in_f = 1'b0; in_e = 1'b0; f_bad = 1'b0; e_bad = 1'b0; f_len = 0; e_len = 0;
    f_addr = '0; e_pc = '0; e_inst = '0; e_pc4 = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_f = 1'b0;
        in_e = 1'b0;
      end else begin
        if (m_req) begin
          if (!in_f) begin
            in_f = 1'b1; f_len = 0; f_addr = m_addr; f_bad = 1'b0;
          end
          if (m_addr !== f_addr) f_bad = 1'b1;
          f_len++;
        end else if (in_f) begin
          in_f = 1'b0;
          if (fch_q.size() == 0) fail("fetch_unexpected");
          else begin
            fr = fch_q.pop_front();
            chk("fetch_addr", f_addr, fr.addr);
            chk("fetch_req_len", f_len, fr.len);
            chk("fetch_addr_stable", {31'b0, f_bad}, 32'd0);
          end
        end
        if (m_valid) begin
          if (!in_e) begin
            in_e = 1'b1; e_len = 0; e_bad = 1'b0;
            e_pc = m_pc; e_inst = m_inst; e_pc4 = m_pc4;
          end
          if (m_pc !== e_pc || m_inst !== e_inst || m_pc4 !== e_pc4) e_bad = 1'b1;
          e_len++;
        end else if (in_e) begin
          in_e = 1'b0;
          if (exe_q.size() == 0) fail("exec_unexpected");
          else begin
            er = exe_q.pop_front();
            chk("exec_pc", e_pc, er.pc);
            chk("exec_inst", e_inst, er.inst);
            chk("exec_pc_plus4", e_pc4, er.pc4);
            chk("exec_valid_len", e_len, er.len);
            chk("exec_stable", {31'b0, e_bad}, 32'd0);
          end
        end
      end
    end
  end

  task automatic reset_check(input logic [31:0] rpc, input logic [31:0] rpc4);
    repeat (2) @(negedge clk);
    chk("rst_pc", m_pc, rpc);
    chk("rst_addr", m_addr, rpc);
    chk("rst_pc_plus4", m_pc4, rpc4);
    chk("rst_inst", m_inst, 32'h0);
    chk("rst_req", {31'b0, m_req}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (exe_q.size() == 0 && fch_q.size() == 0) break;
    end
    if (exe_q.size() != 0 || fch_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d fetch and %0d exec pending expected 0",
               fch_q.size(), exe_q.size());
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    stim_q.delete();
    fch_q.delete();
    exe_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; sel = 2'd0; force_ack = 1'b0; fetch_stall = 1'b0; mon_en = 1'b0;
    n_vec = 0; n_err = 0;

    // Instance 0: RESET_PC = 0, sequential, branches, jump, wait, stall, reset mid-fetch.
    reset_check(32'h0, 32'h4);
    exp_fetch(32'h00, 1); exp_exec(32'h00, 32'h0, 32'h04, 1, 1'b0, 0);
    exp_fetch(32'h04, 1); exp_exec(32'h04, 32'h0, 32'h08, 1, 1'b0, 0);
    exp_fetch(32'h08, 1); exp_exec(32'h08, 32'h0, 32'h0C, 1, 1'b0, 0);
    exp_fetch(32'h0C, 1); exp_exec(32'h0C, 32'h0, 32'h10, 1, 1'b0, 0);
    exp_fetch(32'h10, 1); exp_exec(32'h10, 32'h1000_FFFE, 32'h14, 1, 1'b1, 0);
    exp_fetch(32'h0C, 1); exp_exec(32'h0C, 32'h0, 32'h10, 1, 1'b0, 0);
    exp_fetch(32'h10, 1); exp_exec(32'h10, 32'h1000_FFFE, 32'h14, 1, 1'b0, 0);
    exp_fetch(32'h14, 1); exp_exec(32'h14, 32'h0800_0008, 32'h18, 1, 1'b0, 0);
    exp_fetch(32'h20, 1); exp_exec(32'h20, 32'h1400_0003, 32'h24, 1, 1'b0, 0);
    exp_fetch(32'h30, 1); exp_exec(32'h30, 32'h0, 32'h34, 1, 1'b0, 0);
    exp_fetch(32'h34, 4); exp_exec(32'h34, 32'h0, 32'h38, 3, 1'b0, 2);
    exp_fetch(32'h38, 2);
    exp_fetch(32'h00, 1); exp_exec(32'h00, 32'h0, 32'h04, 1, 1'b0, 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    chk("first_req", {31'b0, m_req}, 32'd1);
    for (k = 0; k < 300 && !(m_req && m_addr == 32'h38); k++) @(negedge clk);
    chk("reach_fetch_38", {31'b0, (m_req && m_addr == 32'h38)}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midfetch_rst_pc", m_pc, 32'h0);
    chk("midfetch_rst_req", {31'b0, m_req}, 32'd0);
    rst       = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_inst", m_inst, 32'h0);
    chk("late_ack_req", {31'b0, m_req}, 32'd1);
    chk("late_ack_addr", m_addr, 32'h0);
    drain();

    // Instance 1: jump keeps pc_plus4[31:28]; stall held high during FETCH.
    sel = 2'd1;
    reset_check(32'h3000_0000, 32'h3000_0004);
    exp_fetch(32'h3000_0000, 1); exp_exec(32'h3000_0000, 32'h0800_0040, 32'h3000_0004, 1, 1'b0, 0);
    exp_fetch(32'h3000_0100, 1); exp_exec(32'h3000_0100, 32'h0, 32'h3000_0104, 1, 1'b0, 0);
    fetch_stall = 1'b1;
    mon_en      = 1'b1;
    rst         = 1'b0;
    drain();
    fetch_stall = 1'b0;

    // Instance 2: sequential wrap from the top of the address space.
    sel = 2'd2;
    reset_check(32'hFFFF_FFFC, 32'h0);
    exp_fetch(32'hFFFF_FFFC, 1); exp_exec(32'hFFFF_FFFC, 32'h0, 32'h0, 1, 1'b0, 0);
    exp_fetch(32'h0, 1);         exp_exec(32'h0, 32'h0, 32'h4, 1, 1'b0, 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
